// File: rtl/dmem_controller.sv
// Byte-addressable data memory controller: wait states, optional split of word-crossing accesses, sign/zero-extended loads.
// One request in flight; req_ready only in IDLE; rsp_valid is a one-cycle strobe and rsp_rdata/rsp_err hold until the next response.
module dmem_controller #(
    parameter int DM_ADDR          = 16,
    parameter int WAIT_CYCLES      = 1,
    parameter bit ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int WORDS = 2 ** (DM_ADDR - 2);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, SPLIT, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]        mem [WORDS] = '{default: '0};
    logic [3:0]         cnt;
    logic [DM_ADDR-1:0] addr_q;
    logic [1:0]         size_q;
    logic               we_q, uns_q, err_q, cross_q;
    logic [31:0]        wdata_q, win_lo_q;

    // Request decode, evaluated on the raw inputs at acceptance
    logic [2:0]  nm1;
    logic [32:0] last_addr;
    logic        in_cross, in_err, accept, nxt_err;

    always_comb begin
        nm1 = 3'd0;
        case (req_size)
            2'b01:   nm1 = 3'd1;
            2'b10:   nm1 = 3'd3;
            default: nm1 = 3'd0;
        endcase
    end

    assign last_addr = {1'b0, req_addr} + 33'(nm1);
    assign in_cross  = ({1'b0, req_addr[1:0]} + nm1) > 3'd3;
    assign in_err    = (req_size == 2'b11) || (|last_addr[32:DM_ADDR])
                     || (in_cross && (ALLOW_MISALIGNED == 1'b0));
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (WAIT_CYCLES > 0) state_nxt = WAIT;
                else                 state_nxt = in_err ? RESP : ACCESS;
            end
            WAIT:    if (cnt <= 4'd1) state_nxt = err_q ? RESP : ACCESS;
            ACCESS:  state_nxt = cross_q ? SPLIT : RESP;
            SPLIT:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane datapath: a 64-bit window spans the addressed word and the next one
    logic [1:0]         off;
    logic [3:0]         nmask, wr_mask;
    logic [7:0]         mask8;
    logic [63:0]        wide, win;
    logic [DM_ADDR-3:0] widx;
    logic [31:0]        rd_word, wr_bytes, raw, ext;
    logic               wr_en;

    assign off = addr_q[1:0];

    always_comb begin
        nmask = 4'b0001;
        case (size_q)
            2'b01:   nmask = 4'b0011;
            2'b10:   nmask = 4'b1111;
            default: nmask = 4'b0001;
        endcase
    end

    assign widx     = (state == SPLIT) ? addr_q[DM_ADDR-1:2] + 1'b1 : addr_q[DM_ADDR-1:2];
    assign rd_word  = mem[widx];
    assign mask8    = {4'b0000, nmask} << off;
    assign wide     = {32'h0, wdata_q} << {off, 3'b000};
    assign wr_mask  = (state == SPLIT) ? mask8[7:4] : mask8[3:0];
    assign wr_bytes = (state == SPLIT) ? wide[63:32] : wide[31:0];
    assign wr_en    = we_q && ((state == ACCESS) || (state == SPLIT));
    assign win      = (state == SPLIT) ? {rd_word, win_lo_q} : {32'h0, rd_word};
    assign raw      = win[8*off +: 32];

    always_comb begin
        ext = raw;
        case (size_q)
            2'b00: ext = uns_q ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01: ext = uns_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // With zero wait states an erroring request jumps straight from IDLE to RESP
    assign nxt_err = (state == IDLE) ? in_err : err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr[DM_ADDR-1:0];
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                err_q   <= in_err;
                cross_q <= in_cross;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS) win_lo_q <= rd_word;
            if (state_nxt == RESP) begin
                rsp_err   <= nxt_err;
                rsp_rdata <= (nxt_err || we_q) ? 32'h0 : ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_mask[l]) mem[widx][8*l +: 8] <= wr_bytes[8*l +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench: instance 0 uses defaults, instance 1 rejects word-crossing accesses.
module tb_dmem_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
    logic        rsp_valid[2], rsp_err[2];
    logic [1:0]  req_size[2];
    logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
    int checks   = 0;
    int failures = 0;

    dmem_controller u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_controller #(.ALLOW_MISALIGNED(1'b0)) u_dut_strict (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mem_op(input int d, input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int waits = 0;
        bit seen  = 1'b0;
        @(negedge clk);
        while (!req_ready[d] && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
        req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[d]) seen = 1'b1;
        end
        check_eq({tag, "_rsp"}, 32'(seen), 32'd1);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(negedge clk);
        check_eq({tag, "_oneshot"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic do_load(input int d, input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp, input int exp_lat);
        logic [31:0] rd; logic er; int lat;
        mem_op(d, tag, 1'b0, size, uns, addr, 32'h0, rd, er, lat);
        check_eq({tag, "_data"}, rd, exp);
        check_eq({tag, "_err"}, 32'(er), 32'd0);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_store(input int d, input string tag, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        logic [31:0] rd; logic er; int lat;
        mem_op(d, tag, 1'b1, size, 1'b0, addr, wdata, rd, er, lat);
        check_eq({tag, "_data"}, rd, 32'h0);
        check_eq({tag, "_err"}, 32'(er), 32'd0);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_bad(input int d, input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd; logic er; int lat;
        mem_op(d, tag, we, size, 1'b0, addr, wdata, rd, er, lat);
        check_eq({tag, "_err"}, 32'(er), 32'd1);
        check_eq({tag, "_data"}, rd, 32'h0);
    endtask

    initial begin
        int hits;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b00;
            req_unsigned[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("rst_rdata", rsp_rdata[0], 32'h0);
        check_eq("rst_err", 32'(rsp_err[0]), 32'd0);
        check_eq("rst_ready_strict", 32'(req_ready[1]), 32'd1);

        // Split store across the 0x0C/0x10 word boundary, then read both words and split loads
        do_store(0, "sw_split", 2'b10, 32'h0E, 32'h11223344, 4);
        do_load(0, "lw_0c", 2'b10, 1'b0, 32'h0C, 32'h33440000, 3);
        do_load(0, "lw_10a", 2'b10, 1'b0, 32'h10, 32'h00001122, 3);
        do_load(0, "lw_0e", 2'b10, 1'b0, 32'h0E, 32'h11223344, 4);
        do_load(0, "lh_0f", 2'b01, 1'b0, 32'h0F, 32'h00002233, 4);

        do_store(0, "sw_10", 2'b10, 32'h10, 32'hDEADBEEF, 3);
        do_load(0, "lw_10b", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 3);
        do_load(0, "lb_13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE, -1);
        do_load(0, "lbu_13", 2'b00, 1'b1, 32'h13, 32'h000000DE, -1);
        do_load(0, "lh_10", 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF, -1);
        do_load(0, "lhu_12", 2'b01, 1'b1, 32'h12, 32'h0000DEAD, -1);
        repeat (3) @(negedge clk);
        check_eq("hold_rdata", rsp_rdata[0], 32'h0000DEAD);
        check_eq("hold_err", 32'(rsp_err[0]), 32'd0);

        do_store(0, "sb_01", 2'b00, 32'h01, 32'hFFFFFFA5, 3);
        do_load(0, "lw_00", 2'b10, 1'b0, 32'h00, 32'h0000A500, 3);

        do_bad(0, "lw_oor", 1'b0, 2'b10, 32'h00010000, 32'h0);
        do_bad(0, "size11", 1'b0, 2'b11, 32'h04, 32'h0);
        do_bad(0, "lw_fffe", 1'b0, 2'b10, 32'h0000FFFE, 32'h0);
        do_bad(0, "lw_wrap32", 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);
        do_bad(0, "sw_fffe", 1'b1, 2'b10, 32'h0000FFFE, 32'h12345678);
        do_load(0, "lhu_fffe", 2'b01, 1'b1, 32'h0000FFFE, 32'h00000000, -1);
        do_load(0, "lb_ffff", 2'b00, 1'b0, 32'h0000FFFF, 32'h00000000, -1);

        do_bad(1, "sh_03_strict", 1'b1, 2'b01, 32'h03, 32'h0000ABCD);
        do_load(1, "lw_00_strict", 2'b10, 1'b0, 32'h00, 32'h00000000, 3);
        do_store(1, "sh_02_strict", 2'b01, 32'h02, 32'h0000ABCD, 3);
        do_load(1, "lw_00_strict2", 2'b10, 1'b0, 32'h00, 32'hABCD0000, 3);

        // Reset while a store sits in its wait state
        do_load(0, "pre_rst", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 3);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10;
        req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", 32'(req_ready[0]), 32'd1);
        check_eq("midrst_rdata", rsp_rdata[0], 32'h0);
        check_eq("midrst_err", 32'(rsp_err[0]), 32'd0);
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid[0]) hits++;
        end
        check_eq("midrst_no_rsp", 32'(hits), 32'd0);
        do_load(0, "lw_20", 2'b10, 1'b0, 32'h20, 32'h00000000, 3);
        do_load(0, "post_rst_10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
